// File: rtl/mac_pkg.sv
// mac_pkg: widths, limits and the controller state encoding shared by the
// aligned-product accumulator and its helpers.
//   PP_W      - width of an aligned partial product (two's complement)
//   EXP_W     - width of the group exponent
//   ACC_W     - accumulator width; 16 full-scale beats cannot wrap it
//   MAX_BEATS - beats after which an open group is force-closed
//   CNT_W     - beat counter width (holds 0..MAX_BEATS)
//   NUM_W     - width of the primitive gate-count reporting bus
package mac_pkg;

  localparam int PP_W      = 15;
  localparam int EXP_W     = 6;
  localparam int ACC_W     = 19;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 5;
  localparam int NUM_W     = 51;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sign-extend a partial product to accumulator width.
  function automatic logic [ACC_W-1:0] sext_pp(input logic [PP_W-1:0] pp);
    return {{(ACC_W-PP_W){pp[PP_W-1]}}, pp};
  endfunction

endpackage

// File: rtl/ADD.sv
// ADD: W-bit adder primitive (carry out dropped).
//   a, b   - operands
//   sum    - a + b modulo 2^W
//   number - reported gate count of this instance
module ADD #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic [50:0]  number
);

  assign sum    = a + b;
  // One full adder (five gates) per bit.
  assign number = 51'(5 * W);

endmodule

// File: rtl/COM.sv
// COM: W-bit unsigned magnitude comparator primitive.
//   a, b   - operands
//   gt     - 1 when a > b (unsigned)
//   number - reported gate count of this instance
module COM #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic [50:0]  number
);

  assign gt     = (a > b);
  assign number = 51'(4 * W);

endmodule

// File: rtl/EQ.sv
// EQ: W-bit equality comparator primitive.
//   a, b   - operands
//   eq     - 1 when a == b
//   number - reported gate count of this instance
module EQ #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic [50:0]  number
);

  assign eq     = (a == b);
  // XNOR per bit plus the AND reduction tree.
  assign number = 51'(2 * W);

endmodule

// File: rtl/accum_sat.sv
// accum_sat: clamps a full-width group sum into the signed 16-bit range
// -32768..32767 (result still presented sign-extended at ACC_W bits).
//   sum_in  - unclamped accumulator value
//   sum_out - clamped value
//   sat     - 1 when clamping changed the value
module accum_sat
  import mac_pkg::*;
(
  input  logic [ACC_W-1:0] sum_in,
  output logic [ACC_W-1:0] sum_out,
  output logic             sat
);

  localparam int OUT_W = 16;

  logic [ACC_W-OUT_W:0] top_s;
  logic                 ovf_s;

  // The value fits 16 bits only if every bit from bit 15 upward equals the sign.
  always_comb begin
    top_s = sum_in[ACC_W-1:OUT_W-1];
    ovf_s = !((&top_s) || (~|top_s));
    if (ovf_s) begin
      if (sum_in[ACC_W-1]) begin
        sum_out = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      end else begin
        sum_out = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      end
      sat = 1'b1;
    end else begin
      sum_out = sum_in;
      sat     = 1'b0;
    end
  end

endmodule

// File: rtl/align_accum.sv
// align_accum: sums a group of aligned partial products (1..16 beats) and
// hands the group sum plus its exponent to the normalizer.
//   i_clk, i_rst        - clock, asynchronous active-high reset
//   i_valid/o_ready     - beat handshake (o_ready low while a result waits)
//   i_align_pp          - aligned partial product, two's complement
//   i_max_exp           - group exponent, taken from the first beat only
//   i_last              - final beat of the group
//   o_valid/i_ready     - result handshake
//   o_sum, o_exp        - group sum and latched exponent
//   o_len_err           - group closed by the 16-beat limit, not by i_last
//   o_sat               - sum was clamped (always 0 unless saturation built)
//   number              - summed gate count of the arithmetic primitives
// Build option: define MAC_ACCUM_SAT_EN to clamp the sum to 16-bit signed.
module align_accum
  import mac_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [PP_W-1:0]  i_align_pp,
  input  logic [EXP_W-1:0] i_max_exp,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic [EXP_W-1:0] o_exp,
  output logic             o_len_err,
  output logic             o_sat,
  output logic [NUM_W-1:0] number
);

  state_e           state_r, state_next_s;
  logic [ACC_W-1:0] acc_r, sum_r;
  logic [ACC_W-1:0] add_a_s, add_b_s, add_sum_s, clamp_sum_s;
  logic [CNT_W-1:0] cnt_r;
  logic [EXP_W-1:0] exp_r;
  logic             valid_r, len_err_r, sat_r, ready_r;
  logic             clamp_sat_s;
  logic             beat_s, hs_s, close_s, force_s;
  logic             is_idle_s, is_acc_s, is_done_s, cnt_last_s;
  logic [NUM_W-1:0] add_num_s, idle_num_s, acc_num_s, done_num_s, cnt_num_s;

  assign beat_s = i_valid & ready_r;
  assign hs_s   = valid_r & i_ready;

  EQ #(.W(2)) u_eq_idle (.a(state_r), .b(IDLE), .eq(is_idle_s), .number(idle_num_s));
  EQ #(.W(2)) u_eq_acc  (.a(state_r), .b(ACC),  .eq(is_acc_s),  .number(acc_num_s));
  EQ #(.W(2)) u_eq_done (.a(state_r), .b(DONE), .eq(is_done_s), .number(done_num_s));

  // cnt > MAX_BEATS-2 means the beat being accepted now is the last allowed one.
  COM #(.W(CNT_W)) u_cnt_cmp (
    .a(cnt_r), .b(CNT_W'(MAX_BEATS - 2)), .gt(cnt_last_s), .number(cnt_num_s)
  );

  // A group's first beat starts from zero, so one adder serves both states.
  always_comb begin
    add_b_s = sext_pp(i_align_pp);
    if (is_idle_s) begin
      add_a_s = '0;
    end else begin
      add_a_s = acc_r;
    end
  end

  ADD #(.W(ACC_W)) u_add (.a(add_a_s), .b(add_b_s), .sum(add_sum_s), .number(add_num_s));

`ifdef MAC_ACCUM_SAT_EN
  accum_sat u_sat (.sum_in(add_sum_s), .sum_out(clamp_sum_s), .sat(clamp_sat_s));
`else
  assign clamp_sum_s = add_sum_s;
  assign clamp_sat_s = 1'b0;
`endif

  assign number = add_num_s + idle_num_s + acc_num_s + done_num_s + cnt_num_s;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and group-close decode.
  always_comb begin
    state_next_s = state_r;
    close_s      = 1'b0;
    force_s      = 1'b0;
    if (is_idle_s) begin
      if (beat_s) begin
        close_s      = i_last;
        state_next_s = i_last ? DONE : ACC;
      end else begin
        state_next_s = IDLE;
      end
    end else if (is_acc_s) begin
      if (beat_s && i_last) begin
        close_s      = 1'b1;
        state_next_s = DONE;
      end else if (beat_s && cnt_last_s) begin
        close_s      = 1'b1;
        force_s      = 1'b1;
        state_next_s = DONE;
      end else begin
        state_next_s = ACC;
      end
    end else if (is_done_s) begin
      state_next_s = hs_s ? IDLE : DONE;
    end else begin
      state_next_s = IDLE;
    end
  end

  // Accumulator, beat counter, exponent latch and registered result/flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      exp_r     <= '0;
      sum_r     <= '0;
      valid_r   <= 1'b0;
      len_err_r <= 1'b0;
      sat_r     <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      // o_ready is a register so it drops with o_valid and rises only after the handshake.
      ready_r <= (state_next_s != DONE);
      if (beat_s) begin
        acc_r <= add_sum_s;
        if (is_idle_s) begin
          cnt_r <= CNT_W'(1);
          exp_r <= i_max_exp;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else if (hs_s) begin
        cnt_r <= '0;
      end
      if (close_s) begin
        sum_r     <= clamp_sum_s;
        sat_r     <= clamp_sat_s;
        len_err_r <= force_s;
        valid_r   <= 1'b1;
      end else if (hs_s) begin
        valid_r   <= 1'b0;
        len_err_r <= 1'b0;
        sat_r     <= 1'b0;
      end
    end
  end

  assign o_ready   = ready_r;
  assign o_valid   = valid_r;
  assign o_sum     = sum_r;
  assign o_exp     = exp_r;
  assign o_len_err = len_err_r;
  assign o_sat     = sat_r;

endmodule
